// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (datapath core and loader/debug) in front of a single-ported data memory.
// Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with the core winning.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  coreReq,
    input  logic                  coreWrite,
    input  logic [31:0]           coreAddress,
    input  logic [DATA_WIDTH-1:0] coreWriteData,
    output logic                  coreAck,
    output logic [DATA_WIDTH-1:0] coreReadData,
    output logic                  coreError,
    input  logic                  loadReq,
    input  logic                  loadWrite,
    input  logic [31:0]           loadAddress,
    input  logic [DATA_WIDTH-1:0] loadWriteData,
    output logic                  loadAck,
    output logic [DATA_WIDTH-1:0] loadReadData,
    output logic                  loadError,
    output logic [31:0]           memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic                  busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0] state;
    logic       lat_write;
    logic       lat_port;
    logic       any_req;
    logic       grant_port;
    logic       in_range;

    assign any_req  = coreReq | loadReq;
    // memAddress doubles as the latched request address.
    assign in_range = (memAddress < 32'(MEM_DEPTH));
    assign busy     = (state != IDLE);
    assign memWrite = (state == ACCESS) && lat_write && in_range;
    assign memRead  = (state == ACCESS) && !lat_write && in_range;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        grant_port = 1'b0;
        if (coreReq && loadReq) begin
            grant_port = ~last_grant;
        end else if (loadReq) begin
            grant_port = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_port;
        end
    end
`else
    assign grant_port = ~coreReq;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_port     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            coreAck      <= 1'b0;
            loadAck      <= 1'b0;
            coreError    <= 1'b0;
            loadError    <= 1'b0;
            coreReadData <= '0;
            loadReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= ACCESS;
                        lat_port     <= grant_port;
                        lat_write    <= grant_port ? loadWrite : coreWrite;
                        memAddress   <= grant_port ? loadAddress : coreAddress;
                        memWriteData <= grant_port ? loadWriteData : coreWriteData;
                    end
                end
                ACCESS: state <= WAIT;
                WAIT: begin
                    state <= RESP;
                    // Memory read data is valid now, one cycle after the ACCESS strobe.
                    if (!lat_port) begin
                        coreAck   <= 1'b1;
                        coreError <= !in_range;
                        if (!in_range) begin
                            coreReadData <= '0;
                        end else if (!lat_write) begin
                            coreReadData <= memReadData;
                        end
                    end else begin
                        loadAck   <= 1'b1;
                        loadError <= !in_range;
                        if (!in_range) begin
                            loadReadData <= '0;
                        end else if (!lat_write) begin
                            loadReadData <= memReadData;
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    coreAck   <= 1'b0;
                    loadAck   <= 1'b0;
                    coreError <= 1'b0;
                    loadError <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, multi-cycle sequences and a random run against a reference model.
module tb_data_mem_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          coreReq, coreWrite, coreAck, coreError;
    logic [31:0]   coreAddress;
    logic [DW-1:0] coreWriteData, coreReadData;
    logic          loadReq, loadWrite, loadAck, loadError;
    logic [31:0]   loadAddress;
    logic [DW-1:0] loadWriteData, loadReadData;
    logic [31:0]   memAddress;
    logic [DW-1:0] memWriteData, memReadData;
    logic          memWrite, memRead, busy;

    data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .coreReq(coreReq), .coreWrite(coreWrite), .coreAddress(coreAddress),
        .coreWriteData(coreWriteData), .coreAck(coreAck), .coreReadData(coreReadData),
        .coreError(coreError),
        .loadReq(loadReq), .loadWrite(loadWrite), .loadAddress(loadAddress),
        .loadWriteData(loadWriteData), .loadAck(loadAck), .loadReadData(loadReadData),
        .loadError(loadError),
        .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
        .memRead(memRead), .memReadData(memReadData), .busy(busy)
    );

    always #5 clock = ~clock;

    // Registered data memory, cleared together with the arbiter.
    logic [DW-1:0] mem_arr [DEPTH];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
        end else begin
            if (memWrite && memAddress < DEPTH) mem_arr[memAddress[4:0]] <= memWriteData;
            if (memRead && memAddress < DEPTH) memReadData <= mem_arr[memAddress[4:0]];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: word store plus each port's last visible ReadData.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd [2];

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        ref_mem.delete();
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic model_step(input bit port, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] exp_rd, output bit exp_err);
        if (addr >= DEPTH) begin
            exp_err      = 1'b1;
            ref_rd[port] = '0;
        end else begin
            exp_err = 1'b0;
            if (wr) ref_mem[int'(addr)] = wd;
            else    ref_rd[port] = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
        end
        exp_rd = ref_rd[port];
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        chk("rst_ctrl", {busy, coreAck, loadAck, coreError, loadError, memWrite, memRead}, 0);
        chk("rst_rdata", {coreReadData, loadReadData}, 0);
        chk("rst_mem", {memAddress, memWriteData}, 0);
        reset = 1'b0;
        model_reset();
    endtask

    // One access on one port; returns at the following IDLE cycle.
    task automatic do_txn(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output bit err, output int lat,
                          output int nstb, output logic [31:0] stb_addr, output bit stb_wr,
                          output bit other_ack);
        bit got = 0;
        lat = 0; nstb = 0; stb_addr = '0; stb_wr = 0; other_ack = 0;
        if (port) begin
            loadWrite = wr; loadAddress = addr; loadWriteData = wd; loadReq = 1'b1;
        end else begin
            coreWrite = wr; coreAddress = addr; coreWriteData = wd; coreReq = 1'b1;
        end
        while (!got && lat < 20) begin
            tick;
            lat++;
            if (memWrite || memRead) begin
                nstb++;
                stb_addr = memAddress;
                stb_wr   = memWrite;
            end
            if (port ? loadAck : coreAck) begin
                got       = 1;
                other_ack = port ? coreAck : loadAck;
            end
        end
        rd  = port ? loadReadData : coreReadData;
        err = port ? loadError : coreError;
        coreReq = 1'b0;
        loadReq = 1'b0;
        tick;
    endtask

    task automatic check_txn(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd, stb_addr, mrd;
        bit err, stb_wr, oth, merr;
        int lat, nstb;
        do_txn(port, wr, addr, wd, rd, err, lat, nstb, stb_addr, stb_wr, oth);
        model_step(port, wr, addr, wd, mrd, merr);
        chk("latency", lat, 3);
        chk("rdata", rd, exp_rd);
        chk("error", err, exp_err);
        chk("other_ack", oth, 0);
        chk("strobes", nstb, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk("strobe_addr", stb_addr, addr);
            chk("strobe_dir", stb_wr, wr);
        end
    endtask

    initial begin
        int t, t_c, t_l, prev, g;
        bit seen;
        logic [31:0] mrd;
        bit merr;

        tbl[0]  = '{0, 1, 32'd5,          32'hDEADBEEF, 32'h0,        0};
        tbl[1]  = '{0, 0, 32'd5,          32'h0,        32'hDEADBEEF, 0};
        tbl[2]  = '{1, 0, 32'd40,         32'h0,        32'h0,        1};
        tbl[3]  = '{1, 1, 32'd7,          32'h12345678, 32'h0,        0};
        tbl[4]  = '{1, 0, 32'd7,          32'h0,        32'h12345678, 0};
        tbl[5]  = '{0, 1, 32'd31,         32'hA5A5A5A5, 32'hDEADBEEF, 0};
        tbl[6]  = '{0, 0, 32'd31,         32'h0,        32'hA5A5A5A5, 0};
        tbl[7]  = '{0, 1, 32'd32,         32'h11111111, 32'h0,        1};
        tbl[8]  = '{1, 0, 32'd5,          32'h0,        32'hDEADBEEF, 0};
        tbl[9]  = '{0, 0, 32'd7,          32'h0,        32'h12345678, 0};
        tbl[10] = '{1, 0, 32'hFFFFFFFF,   32'h0,        32'h0,        1};

        coreReq = 0; coreWrite = 0; coreAddress = '0; coreWriteData = '0;
        loadReq = 0; loadWrite = 0; loadAddress = '0; loadWriteData = '0;
        do_reset();

        foreach (tbl[i])
            check_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err);

        // Both requests held for four grants.
        do_reset();
        coreWrite = 0; coreAddress = 32'd1; coreReq = 1;
        loadWrite = 0; loadAddress = 32'd2; loadReq = 1;
        t = 0; prev = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            while (!seen && t < 40) begin
                tick;
                t++;
                if (coreAck || loadAck) seen = 1;
            end
            g = loadAck ? 1 : 0;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
            chk("rr_grant", g, k % 2);
`else
            chk("fixed_grant", g, 0);
`endif
            chk("grant_spacing", t - prev, (k == 0) ? 3 : 4);
            prev = t;
        end
        coreReq = 0; loadReq = 0;
        tick;

        // Load request arriving while the core access is in ACCESS.
        coreWrite = 1; coreAddress = 32'd3; coreWriteData = 32'h33; coreReq = 1;
        tick;
        loadWrite = 0; loadAddress = 32'd3; loadReq = 1;
        t = 1; t_c = 0; t_l = 0;
        while (t_c == 0 && t < 20) begin
            tick; t++;
            if (coreAck) t_c = t;
            if (loadAck) t_l = t;
        end
        coreReq = 0;
        chk("core_ack_time", t_c, 3);
        while (t_l == 0 && t < 30) begin
            tick; t++;
            if (loadAck) t_l = t;
        end
        chk("load_after_core", t_l - t_c, 4);
        chk("load_rdata", loadReadData, 32'h33);
        loadReq = 0;
        tick;
        model_step(0, 1, 32'd3, 32'h33, mrd, merr);
        model_step(1, 0, 32'd3, 32'h0, mrd, merr);

        // Reset during WAIT of a core read aborts it without an Ack.
        coreWrite = 0; coreAddress = 32'd3; coreReq = 1;
        tick;
        tick;
        chk("in_wait_busy", busy, 1);
        reset = 1; coreReq = 0;
        tick;
        chk("abort_ctrl", {busy, coreAck, loadAck, coreError, loadError, memWrite, memRead}, 0);
        chk("abort_data", {coreReadData, loadReadData, memAddress, memWriteData}, 0);
        reset = 0;
        model_reset();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (coreAck || loadAck || busy) seen = 1;
        end
        chk("no_ack_after_abort", seen, 0);

        // Random single-port traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] rd, stb_addr, addr, wd;
            bit err, stb_wr, oth, port, wr;
            int lat, nstb;
            port = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 39);
            wd   = $urandom;
            do_txn(port, wr, addr, wd, rd, err, lat, nstb, stb_addr, stb_wr, oth);
            model_step(port, wr, addr, wd, mrd, merr);
            chk("rnd_latency", lat, 3);
            chk("rnd_rdata", rd, mrd);
            chk("rnd_error", err, merr);
            chk("rnd_strobes", nstb, merr ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-003 Parameter MEM_DEPTH, default 32, SHALL set the number of valid word addresses (0..MEM_DEPTH-1).
REQ-004 Ports SHALL be, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- coreReq  in  1  port 0 (datapath) access request
- coreWrite  in  1  port 0: 1 = write, 0 = read
- coreAddress  in  32  port 0 word address
- coreWriteData  in  DATA_WIDTH  port 0 store data
- coreAck  out  1  port 0 completion pulse
- coreReadData  out  DATA_WIDTH  port 0 load data
- coreError  out  1  port 0 out-of-range flag, valid with coreAck
- loadReq, loadWrite, loadAddress, loadWriteData, loadAck, loadReadData, loadError: same directions, widths and meanings for port 1 (loader/debug).
- memAddress  out  32  address to data memory
- memWriteData  out  DATA_WIDTH  write data to data memory
- memWrite  out  1  memory write strobe
- memRead  out  1  memory read strobe
- memReadData  in  DATA_WIDTH  memory read data, registered by the memory, valid the cycle after memRead
- busy  out  1  high in every state except IDLE

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, WAIT, RESP. Transitions: IDLE->ACCESS when any request is high, otherwise stay in IDLE; ACCESS->WAIT, WAIT->RESP and RESP->IDLE unconditionally.
REQ-006 On the IDLE->ACCESS edge, the block SHALL latch the granted port's write, address and write data into internal registers and record the granted port.
REQ-007 In ACCESS, mem* outputs SHALL be driven from the latched values, with memWrite or memRead high for exactly that one cycle; outside ACCESS, memWrite = memRead = 0 and memAddress/memWriteData hold their last values.
REQ-008 On the WAIT->RESP edge, for a read, the block SHALL copy memReadData into the granted port's ReadData register; for a write, that register is unchanged.
REQ-009 In RESP, the granted port's Ack SHALL be high for exactly one cycle and the other port's Ack SHALL be low.
- Latency: request sampled in IDLE at cycle N -> Ack high in cycle N+3.
- Throughput: at most one access every 4 cycles.
REQ-010 A requester SHALL hold Req and its request fields stable until its Ack; a Req dropped before grant SHALL NOT be serviced; a Req still high in the cycle after Ack SHALL be treated as a new request.
REQ-011 Each ReadData register SHALL hold its value until the next read completion for that port.
REQ-012 If the latched address is >= MEM_DEPTH, the block SHALL assert neither memWrite nor memRead, and in RESP it SHALL load ReadData with 0 and assert Error together with Ack; Error SHALL otherwise be 0.
REQ-013 With both requests high in IDLE, arbitration SHALL follow REQ-017; with only one request high, that port SHALL be granted regardless of history.
REQ-014 Requests arriving while busy is high SHALL wait, and SHALL NOT be latched until the next IDLE cycle.

Reset
REQ-015 When reset is high at a rising edge, the block SHALL enter IDLE and clear memWrite, memRead, memAddress, memWriteData, both Ack, both ReadData, both Error, busy and the last-grant register (last grant = port 1, so port 0 wins first).
REQ-016 Reset in any non-IDLE state SHALL abort the access with no Ack. A write strobed in ACCESS may still be taken by the memory on that edge, and the block SHALL NOT retry it.

Configuration
REQ-017 Macro DATA_MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: on simultaneous requests, grant the port not granted last; the last-grant register updates on every grant.
- Undefined: fixed priority, with port 0 (core) always winning; the last-grant register is absent.

Verification
REQ-018 The bench SHALL cover:
- Core write addr 5, data 0xDEADBEEF, then core read addr 5 -> memWrite high 1 cycle with memAddress=5; coreAck at N+3; then coreReadData=0xDEADBEEF, coreError=0.
- Load read addr 40 (MEM_DEPTH=32) -> no mem strobe; loadAck at N+3 with loadError=1, loadReadData=0.
- Both Req held continuously for 4 grants, ROUND_ROBIN_EN defined -> grant order core, load, core, load. Macro undefined -> core four times, load starved.
- loadReq raised during a core access in ACCESS -> load latched only at the next IDLE; loadAck 4 cycles after coreAck.
- Reset asserted in WAIT of a core read -> no coreAck; all outputs 0 the next cycle; state IDLE; busy=0.
